// File: rtl/wb_mem_responder.sv
// wb_mem_responder: classic Wishbone B4 RAM responder with byte-lane writes,
// programmable wait states and out-of-range error termination.
module wb_mem_responder #(
    parameter int    MEM_WORDS   = 4096,
    parameter int    ADDR_WIDTH  = 12,
    parameter int    LATENCY     = 0,
    parameter string MEMORY_FILE = ""
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  oor_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [31:0]           wdata_q;
    logic                  resp_err;

    logic [31:0]           mem [MEM_WORDS];

    logic                  req;
    logic                  accept;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] idx_in;
    logic                  oor_in;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic                  c_oor;
    logic                  c_we;
    logic [3:0]            c_sel;
    logic [31:0]           c_wdata;
    logic                  unused_addr_lsb;

    assign req             = wb_cyc_i & wb_stb_i;
    assign accept          = (state == S_IDLE) & req;
    assign idx_in          = wb_addr_i[ADDR_WIDTH+1:2];
    assign oor_in          = {2'b00, wb_addr_i[31:2]} >= 32'(MEM_WORDS);
    assign unused_addr_lsb = ^wb_addr_i[1:0];
    assign commit          = (state_nxt == S_RESP) & ~rst_core;

    // With zero wait states the commit edge is the accept edge, so use live inputs
    always_comb begin
        c_idx   = idx_q;
        c_oor   = oor_q;
        c_we    = we_q;
        c_sel   = sel_q;
        c_wdata = wdata_q;
        if (state == S_IDLE) begin
            c_idx   = idx_in;
            c_oor   = oor_in;
            c_we    = wb_we_i;
            c_sel   = wb_sel_i;
            c_wdata = wb_data_i;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (!wb_cyc_i)              state_nxt = S_IDLE;
                else if (wait_cnt == 4'd1) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        if (state == S_RESP) begin
            wb_ack_o = ~resp_err;
            wb_err_o = resp_err;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wait_cnt  <= 4'd0;
            idx_q     <= '0;
            oor_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            wdata_q   <= 32'd0;
            resp_err  <= 1'b0;
            wb_data_o <= 32'd0;
        end else begin
            if (accept) begin
                wait_cnt <= 4'(LATENCY);
                idx_q    <= idx_in;
                oor_q    <= oor_in;
                we_q     <= wb_we_i;
                sel_q    <= wb_sel_i;
                wdata_q  <= wb_data_i;
            end else if (state == S_WAIT) begin
                wait_cnt <= wb_cyc_i ? wait_cnt - 4'd1 : 4'd0;
            end
            if (commit) begin
                resp_err <= c_oor;
                if (c_oor)      wb_data_o <= 32'd0;
                else if (!c_we) wb_data_o <= mem[c_idx];
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (commit && c_we && !c_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (0, 3 and 4 wait states)
// driven by directed and random transfers against a word-array model.
module tb_wb_mem_responder;

    localparam int N  = 3;
    localparam int MW = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc  [N];
    logic        stb  [N];
    logic        we   [N];
    logic        ack  [N];
    logic        err  [N];
    logic [3:0]  sel  [N];
    logic [31:0] addr [N];
    logic [31:0] wdat [N];
    logic [31:0] rdat [N];

    logic [31:0] model [N][MW];
    logic [31:0] last  [N];
    int          ntests = 0;
    int          nfail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wb_mem_responder #(
            .MEM_WORDS  (MW),
            .ADDR_WIDTH (12),
            .LATENCY    (g == 0 ? 0 : g + 2),
            .MEMORY_FILE("")
        ) u_dut (
            .clk_core  (clk),
            .rst_core  (rst),
            .wb_cyc_i  (cyc[g]),
            .wb_stb_i  (stb[g]),
            .wb_we_i   (we[g]),
            .wb_sel_i  (sel[g]),
            .wb_addr_i (addr[g]),
            .wb_data_i (wdat[g]),
            .wb_data_o (rdat[g]),
            .wb_ack_o  (ack[g]),
            .wb_err_o  (err[g])
        );
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(int u, string tag);
        chk($sformatf("u%0d %s ack", u, tag), {31'd0, ack[u]}, 32'd0);
        chk($sformatf("u%0d %s err", u, tag), {31'd0, err[u]}, 32'd0);
    endtask

    // One complete transfer with cycle-exact termination checks
    task automatic xfer(int u, bit w, logic [31:0] a, logic [3:0] s,
                        logic [31:0] d);
        int          lat  = (u == 0) ? 0 : u + 2;
        bit          oor  = (a[31:2] >= 30'(MW));
        logic [11:0] ix   = a[13:2];
        logic [31:0] prev = last[u];
        if (oor)     last[u] = 32'd0;
        else if (!w) last[u] = model[u][ix];
        if (w && !oor) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[u][ix][8*b +: 8] = d[8*b +: 8];
        end
        cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w;
        sel[u] = s; addr[u] = a; wdat[u] = d;
        for (int j = 0; j <= lat; j++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("u%0d a=%h j%0d ack", u, a, j), {31'd0, ack[u]},
                {31'd0, (j == lat) && !oor});
            chk($sformatf("u%0d a=%h j%0d err", u, a, j), {31'd0, err[u]},
                {31'd0, (j == lat) && oor});
            chk($sformatf("u%0d a=%h j%0d data", u, a, j), rdat[u],
                (j == lat) ? last[u] : prev);
            if (j < lat) begin
                addr[u] = $urandom; wdat[u] = $urandom;
                sel[u] = 4'($urandom); we[u] = 1'($urandom);
            end
        end
        cyc[u] = 1'b0; stb[u] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_quiet(u, "post");
    endtask

    initial begin
        logic [31:0] old;
        logic [31:0] nv;
        for (int u = 0; u < N; u++) begin
            cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
            sel[u] = 4'd0; addr[u] = 32'd0; wdat[u] = 32'd0;
            last[u] = 32'd0;
        end
        #2;
        for (int u = 0; u < N; u++) begin
            chk_quiet(u, "reset");
            chk($sformatf("u%0d reset data", u), rdat[u], 32'd0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int u = 0; u < N; u++)
            for (int i = 0; i < 32; i++)
                xfer(u, 1'b1, 32'(i * 4), 4'hF, $urandom | 32'd1);

        // Read of word 3, single-cycle ack
        xfer(0, 1'b1, 32'h0C, 4'hF, 32'h12345678);
        xfer(0, 1'b0, 32'h0C, 4'h0, 32'd0);
        chk("read word3", rdat[0], 32'h12345678);

        // Byte lanes and sel=0
        xfer(0, 1'b1, 32'h10, 4'hF, 32'h11223344);
        xfer(0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'd0);
        chk("byte lanes", rdat[0], 32'h11BB33DD);
        xfer(0, 1'b1, 32'h13, 4'h0, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'd0);
        chk("sel zero", rdat[0], 32'h11BB33DD);

        // Out of range: err, zero data, wrapped word untouched
        xfer(0, 1'b0, 32'h4, 4'hF, 32'd0);
        xfer(0, 1'b1, 32'(MW * 4), 4'hF, 32'hFFFFFFFF);
        chk("oor data", rdat[0], 32'd0);
        xfer(0, 1'b0, 32'h0, 4'hF, 32'd0);
        xfer(0, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'd0);

        // Strobe held: ack every 2+LATENCY cycles
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0;
        sel[1] = 4'hF; addr[1] = 32'd0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("held j%0d ack", j), {31'd0, ack[1]},
                {31'd0, (j % 5) == 3});
            chk($sformatf("held j%0d err", j), {31'd0, err[1]}, 32'd0);
            if ((j % 5) == 3)
                chk($sformatf("held j%0d data", j), rdat[1], model[1][0]);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        last[1] = model[1][0];
        @(posedge clk); @(negedge clk);
        chk_quiet(1, "held end");

        // Cycle drop in the second wait cycle cancels the write
        old = model[2][8];
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        sel[2] = 4'hF; addr[2] = 32'h20; wdat[2] = ~old;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); @(negedge clk);
            chk_quiet(2, $sformatf("drop j%0d", j));
        end
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); @(negedge clk);
            chk_quiet(2, $sformatf("dropped j%0d", j));
        end
        xfer(2, 1'b0, 32'h20, 4'hF, 32'd0);
        chk("drop readback", rdat[2], old);

        // Reset in the response cycle clears outputs at once
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
        sel[0] = 4'hF; addr[0] = 32'h0C;
        @(posedge clk); @(negedge clk);
        chk("resp ack pre-rst", {31'd0, ack[0]}, 32'd1);
        chk("resp data pre-rst", rdat[0], 32'h12345678);
        rst = 1'b1;
        #1;
        chk_quiet(0, "rst in resp");
        chk("rst in resp data", rdat[0], 32'd0);
        for (int u = 0; u < N; u++) last[u] = 32'd0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_quiet(0, "after rst");

        // Reset in the middle of a wait drops the pending write
        xfer(2, 1'b0, 32'h4, 4'hF, 32'd0);
        old = model[2][16];
        nv  = ~old;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        sel[2] = 4'hF; addr[2] = 32'h40; wdat[2] = nv;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); @(negedge clk);
            chk_quiet(2, $sformatf("prerst j%0d", j));
        end
        rst = 1'b1;
        #1;
        chk_quiet(2, "rst in wait");
        chk("rst in wait data", rdat[2], 32'd0);
        for (int u = 0; u < N; u++) last[u] = 32'd0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        xfer(2, 1'b0, 32'h40, 4'hF, 32'd0);
        chk("rst wait readback", rdat[2], old);
        xfer(2, 1'b1, 32'h40, 4'hF, nv);
        xfer(2, 1'b0, 32'h40, 4'hF, 32'd0);
        chk("post rst write", rdat[2], nv);

        // Random traffic against the model
        for (int k = 0; k < 60; k++) begin
            int          u = k % N;
            logic [31:0] a;
            if (($urandom % 8) == 0)
                a = 32'(MW * 4) + 32'($urandom % 64);
            else
                a = 32'($urandom % 128);
            xfer(u, 1'($urandom), a, 4'($urandom), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
